// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader.
// State encoding and word geometry.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word packer.
// Tracks byte position, assembled word and last flag.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  data,
    input  logic        last_in,
    output logic [31:0] word,
    output logic        last,
    output logic        full
);

    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;

    // Place each byte at its lane; clear drops any partial word
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        last_d = last_q;
        if (clr) begin
            cnt_d  = '0;
            word_d = '0;
            last_d = 1'b0;
        end else if (push) begin
            word_d[{cnt_q, 3'b000} +: 8] = data;
            cnt_d  = cnt_q + BCNT_W'(1);
            last_d = last_in;
        end
    end

    // Packer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
            last_q <= last_d;
        end
    end

    assign word = word_q;
    assign last = last_q;
    assign full = push & ((cnt_q == BCNT_W'(BYTES_PER_WORD - 1)) | last_in);

endmodule

// File: rtl/prog_loader.sv
// Streams a byte-serial image into RAM, then pulses cpu_load.
// Owns the RAM bus while loading, else passes the CPU bus through.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned ADDR_INC   = 1,
    parameter int unsigned MAX_WORDS  = 1024,
    parameter int unsigned LOAD_PULSE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_dout,
    input  logic        cpu_rd_en,
    input  logic        cpu_wr_en,
    output logic [31:0] cpu_din,
    output logic        cpu_load,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words
);

    localparam int PCW = (LOAD_PULSE > 1) ? $clog2(LOAD_PULSE) : 1;

    state_e         state_q, state_d;
    logic           start_q;
    logic [31:0]    addr_q, addr_d;
    logic [15:0]    words_q, words_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [PCW-1:0] pulse_q, pulse_d;

    logic        start_rise;
    logic        ld_wr;
    logic        pk_clr, pk_push, pk_full, pk_last;
    logic [31:0] pk_word;

    assign start_rise = start & ~start_q;

    byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clr     (pk_clr),
        .push    (pk_push),
        .data    (ld_data),
        .last_in (ld_last),
        .word    (pk_word),
        .last    (pk_last),
        .full    (pk_full)
    );

    // Next-state, counters and loader-side strobes
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        words_d  = words_q;
        done_d   = done_q;
        err_d    = err_q;
        pulse_d  = pulse_q;
        pk_clr   = 1'b0;
        pk_push  = 1'b0;
        ld_ready = 1'b0;
        busy     = 1'b0;
        ld_wr    = 1'b0;
        cpu_load = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start_rise) begin
                    state_d = ST_RECV;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    addr_d  = BASE_ADDR;
                    pk_clr  = 1'b1;
                end
            end
            ST_RECV: begin
                busy     = 1'b1;
                ld_ready = 1'b1;
                pk_push  = ld_valid;
                if (pk_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy   = 1'b1;
                ld_wr  = 1'b1;
                pk_clr = 1'b1;
                addr_d = addr_q + 32'(ADDR_INC);
                if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
                if (pk_last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pulse_d = '0;
                end else if (32'(words_q) + 32'd1 == 32'(MAX_WORDS)) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_DONE: begin
                cpu_load = 1'b1;
                if (pulse_q == PCW'(LOAD_PULSE - 1)) state_d = ST_IDLE;
                else pulse_d = pulse_q + PCW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            addr_q  <= BASE_ADDR;
            words_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            addr_q  <= addr_d;
            words_q <= words_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
        end
    end

    assign mem_adr   = busy ? addr_q  : cpu_adr;
    assign mem_din   = busy ? pk_word : cpu_dout;
    assign mem_wr_en = busy ? ld_wr   : cpu_wr_en;
    assign mem_rd_en = busy ? 1'b0    : cpu_rd_en;
    assign cpu_din   = mem_dout;

    assign done  = done_q;
    assign err   = err_q;
    assign words = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader with a small RAM model.
// Directed cases plus random images against a word-packing model.
module tb_prog_loader;

    localparam int MAXW = 2;
    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic [31:0] cpu_adr = '0;
    logic [31:0] cpu_dout = '0;
    logic        cpu_rd_en = 1'b0;
    logic        cpu_wr_en = 1'b0;
    logic [31:0] cpu_din;
    logic        cpu_load;
    logic [31:0] mem_adr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [16];
    logic        mem_clr = 1'b0;
    int          wr_cnt = 0;

    prog_loader #(.MAX_WORDS(MAXW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .cpu_adr   (cpu_adr),
        .cpu_dout  (cpu_dout),
        .cpu_rd_en (cpu_rd_en),
        .cpu_wr_en (cpu_wr_en),
        .cpu_din   (cpu_din),
        .cpu_load  (cpu_load),
        .mem_adr   (mem_adr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .words     (words)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write, asynchronous read, write counter
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= SENT;
            wr_cnt <= 0;
        end else if (mem_wr_en) begin
            mem[mem_adr[3:0]] <= mem_din;
            wr_cnt <= wr_cnt + 1;
        end
    end

    assign mem_dout = mem[mem_adr[3:0]];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        @(negedge clk);
        mem_clr = 1'b1;
        @(negedge clk);
        mem_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte; returns at the negedge after it is accepted
    task automatic send_byte(input logic [7:0] b, input bit last,
                             input bit gap);
        int n;
        if (gap) begin
            ld_valid = 1'b0;
            @(negedge clk);
        end
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        n = 0;
        while (ld_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ld_ready", 32'(ld_ready), 32'd1);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] b[$],
                                               input int idx);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++)
            if (4 * idx + k < b.size())
                w = w | (32'(b[4 * idx + k]) << (8 * k));
        return w;
    endfunction

    // Full image with ld_last on the final byte; checks timing and RAM
    task automatic run_image(input logic [7:0] b[$], input bit gaps,
                             input bit poke);
        int nw;
        nw = (b.size() + 3) / 4;
        clear_mem();
        pulse_start();
        check("words_clr", 32'(words), 32'd0);
        check("done_clr", 32'(done), 32'd0);
        for (int i = 0; i < b.size(); i++) begin
            if (i == 1) begin
                cpu_adr   = 32'd7;
                cpu_wr_en = 1'b1;
                cpu_rd_en = 1'b1;
                #1;
                check("cpu_wr_drop", 32'(mem_wr_en), 32'd0);
                check("cpu_rd_drop", 32'(mem_rd_en), 32'd0);
                check("busy_adr", mem_adr, 32'd0);
                cpu_adr   = '0;
                cpu_wr_en = 1'b0;
                cpu_rd_en = 1'b0;
            end
            if (poke && i == 3) pulse_start();
            send_byte(b[i], i == b.size() - 1, gaps && (i % 2 == 1));
        end
        check("wr_cycle", 32'(mem_wr_en), 32'd1);
        check("wr_adr", mem_adr, 32'(nw - 1));
        check("load_early", 32'(cpu_load), 32'd0);
        @(negedge clk);
        check("load_1", 32'(cpu_load), 32'd1);
        check("done_set", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("load_2", 32'(cpu_load), 32'd1);
        @(negedge clk);
        check("load_end", 32'(cpu_load), 32'd0);
        for (int i = 0; i < nw; i++)
            check($sformatf("ram%0d", i), mem[i], model_word(b, i));
        check("ram_next", mem[nw], SENT);
        check("words", 32'(words), 32'(nw));
        check("wr_cnt", 32'(wr_cnt), 32'(nw));
        check("err_ok", 32'(err), 32'd0);
    endtask

    initial begin
        logic [7:0] img[$];

        // Reset state and passthrough
        cpu_adr   = 32'd5;
        cpu_dout  = 32'h1234_5678;
        cpu_wr_en = 1'b1;
        cpu_rd_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_load", 32'(cpu_load), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_words", 32'(words), 32'd0);
        check("pt_adr", mem_adr, 32'd5);
        check("pt_din", mem_din, 32'h1234_5678);
        check("pt_wr", 32'(mem_wr_en), 32'd1);
        check("pt_rd", 32'(mem_rd_en), 32'd1);
        cpu_adr   = '0;
        cpu_dout  = '0;
        cpu_wr_en = 1'b0;
        cpu_rd_en = 1'b0;
        reset     = 1'b0;

        // 01..08, last on 08; start pulse mid-image must be ignored
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_image(img, 1'b0, 1'b1);
        check("c1_w0", mem[0], 32'h0403_0201);
        check("c1_w1", mem[1], 32'h0807_0605);

        // Processor read after done
        @(negedge clk);
        cpu_adr   = 32'd1;
        cpu_rd_en = 1'b1;
        #1;
        check("cpu_rd_en", 32'(mem_rd_en), 32'd1);
        check("cpu_din", cpu_din, 32'h0807_0605);
        cpu_adr   = '0;
        cpu_rd_en = 1'b0;

        // Same image with valid gaps
        run_image(img, 1'b1, 1'b0);
        check("gap_w1", mem[1], 32'h0807_0605);

        // Partial final word is zero padded
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_image(img, 1'b0, 1'b0);
        check("c2_w1", mem[1], 32'h0000_00EE);

        // Overflow: no last after MAXW words
        clear_mem();
        pulse_start();
        for (int i = 0; i < 4 * MAXW; i++)
            send_byte(8'(8'h10 + i), 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_done", 32'(done), 32'd0);
        check("ovf_busy", 32'(busy), 32'd0);
        check("ovf_words", 32'(words), 32'(MAXW));
        ld_valid = 1'b1;
        ld_data  = 8'h55;
        repeat (6) @(negedge clk);
        check("ovf_ready", 32'(ld_ready), 32'd0);
        ld_valid = 1'b0;
        check("ovf_w0", mem[0], 32'h1312_1110);
        check("ovf_w1", mem[1], 32'h1716_1514);
        check("ovf_w2", mem[2], SENT);
        check("ovf_cnt", 32'(wr_cnt), 32'(MAXW));

        // Restart from the error state
        img = '{8'h21, 8'h22, 8'h23};
        run_image(img, 1'b0, 1'b0);

        // Reset in the middle of a load
        clear_mem();
        pulse_start();
        for (int i = 0; i < 6; i++)
            send_byte(8'(8'h40 + i), 1'b0, 1'b0);
        check("mid_busy", 32'(busy), 32'd1);
        cpu_adr = 32'd9;
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_adr", mem_adr, 32'd9);
        check("rst_async_ready", 32'(ld_ready), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        cpu_adr = '0;
        repeat (3) @(negedge clk);
        check("rst_wr_cnt", 32'(wr_cnt), 32'd1);
        check("rst_w1", mem[1], SENT);
        img = '{8'h91, 8'h92, 8'h93, 8'h94};
        run_image(img, 1'b0, 1'b0);

        // Random images
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 4 * MAXW);
            img.delete();
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            run_image(img, 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
